// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, one-hot status codes, the "no register" ID
// and the pipeline controller state type.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] S_AOK = 4'b1000;
  localparam logic [3:0] S_ADR = 4'b0100;
  localparam logic [3:0] S_INS = 4'b0010;
  localparam logic [3:0] S_HLT = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-controller bundle: stage fields in, stall/bubble strobes,
// status and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic [3:0]       m_Stat;
  logic [3:0]       W_Stat;
  logic [3:0]       W_icode;

  logic             F_stall;
  logic             D_stall;
  logic             W_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             set_cc;
  logic [3:0]       proc_stat;
  logic             running;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] misp_cnt;

  modport master (
    output start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_Stat, W_Stat, W_icode,
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
           set_cc, proc_stat, running, cyc_cnt, ret_cnt, stall_cnt, misp_cnt
  );

  modport slave (
    input  start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_Stat, W_Stat, W_icode,
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
           set_cc, proc_stat, running, cyc_cnt, ret_cnt, stall_cnt, misp_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 five-stage pipeline control: hazard stall/bubble strobes, CC enable,
// run/halt FSM. Define PERF_CNT_EN to build the saturating performance counters.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  ctrl_state_t r_state;
  logic [3:0]  r_proc_stat;

  logic w_run;
  logic w_lu;
  logic w_rt;
  logic w_mp;
  logic w_w_exc;
  logic w_exc;

  logic w_f_stall, w_d_stall, w_w_stall;
  logic w_d_bubble, w_e_bubble, w_m_bubble;
  logic w_set_cc;

  assign w_run   = (r_state == RUN);
  assign w_lu    = ((bus.E_icode == I_MRMOV) || (bus.E_icode == I_POP)) &&
                   (bus.E_dstM != RNONE) &&
                   ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  assign w_rt    = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                   (bus.M_icode == I_RET);
  assign w_mp    = (bus.E_icode == I_JXX) && !bus.e_Cnd;
  assign w_w_exc = (bus.W_Stat != S_AOK);
  assign w_exc   = (bus.m_Stat != S_AOK) || w_w_exc;

  // NOTE: every output gets its frozen-pipeline value first, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_f_stall  = 1'b1;
    w_d_stall  = 1'b1;
    w_w_stall  = 1'b1;
    w_d_bubble = 1'b0;
    w_e_bubble = 1'b1;
    w_m_bubble = 1'b1;
    w_set_cc   = 1'b0;
    if (w_run) begin
      w_f_stall  = w_lu | w_rt;
      w_d_stall  = w_lu;
      w_w_stall  = w_w_exc;
      // A load/use stall in D outranks a RET bubble so D is never stalled and bubbled together.
      w_d_bubble = w_mp | (w_rt & ~w_lu);
      w_e_bubble = w_mp | w_lu;
      w_m_bubble = w_exc;
      w_set_cc   = (bus.E_icode == I_OPQ) & ~w_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_proc_stat <= S_AOK;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) r_state <= RUN;
        end
        RUN: begin
          if (w_w_exc) begin
            r_state     <= HALTED;
            r_proc_stat <= bus.W_Stat;
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.F_stall   = w_f_stall;
  assign bus.D_stall   = w_d_stall;
  assign bus.W_stall   = w_w_stall;
  assign bus.D_bubble  = w_d_bubble;
  assign bus.E_bubble  = w_e_bubble;
  assign bus.M_bubble  = w_m_bubble;
  assign bus.set_cc    = w_set_cc;
  assign bus.proc_stat = r_proc_stat;
  assign bus.running   = w_run;

  // Bubbles enter W as NOPs, so W_icode != NOP with AOK status is a real retirement.
  logic w_ret_inc;
  assign w_ret_inc = w_run && (bus.W_icode != I_NOP) && (bus.W_Stat == S_AOK);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] w_cyc_cnt, w_ret_cnt, w_stall_cnt, w_misp_cnt;

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_run), .q(w_cyc_cnt)
  );
  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_ret_inc), .q(w_ret_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_run & w_f_stall), .q(w_stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_misp_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_run & w_mp), .q(w_misp_cnt)
  );

  assign bus.cyc_cnt   = w_cyc_cnt;
  assign bus.ret_cnt   = w_ret_cnt;
  assign bus.stall_cnt = w_stall_cnt;
  assign bus.misp_cnt  = w_misp_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_ret_inc;

  assign bus.cyc_cnt   = '0;
  assign bus.ret_cnt   = '0;
  assign bus.stall_cnt = '0;
  assign bus.misp_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// responses, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  import y86_pkg::*;

  localparam int CW = 4;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, running}
  localparam logic [7:0] C_IDLE = 8'b1110_1100;
  localparam logic [7:0] C_RUN  = 8'b0000_0001;
  localparam logic [7:0] C_LU   = 8'b1100_1001;
  localparam logic [7:0] C_MP   = 8'b0001_1001;
  localparam logic [7:0] C_RT   = 8'b1001_0001;
  localparam logic [7:0] C_OPQ  = 8'b0000_0011;
  localparam logic [7:0] C_MEXC = 8'b0000_0101;
  localparam logic [7:0] C_WEXC = 8'b0010_0101;

  typedef struct {
    logic       start;
    logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
    logic       e_cnd;
    logic [3:0] m_icode, m_stat, w_stat, w_icode;
  } vec_t;

  typedef struct {
    string         name;
    logic [7:0]    ctrl;
    logic [3:0]    stat;
    logic [CW-1:0] cyc, ret, stl, msp;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  logic [CW-1:0] m_cyc, m_ret, m_stl, m_msp;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t nv();
    vec_t v;
    v.start   = 1'b0;
    v.d_icode = I_NOP;
    v.srca    = RNONE;
    v.srcb    = RNONE;
    v.e_icode = I_NOP;
    v.e_dstm  = RNONE;
    v.e_cnd   = 1'b0;
    v.m_icode = I_NOP;
    v.m_stat  = S_AOK;
    v.w_stat  = S_AOK;
    v.w_icode = I_NOP;
    return v;
  endfunction

  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] x);
    if (PERF && (x != {CW{1'b1}})) return x + CW'(1);
    return x;
  endfunction

  task automatic drive(input vec_t v);
    bus.start   = v.start;
    bus.D_icode = v.d_icode;
    bus.d_srcA  = v.srca;
    bus.d_srcB  = v.srcb;
    bus.E_icode = v.e_icode;
    bus.E_dstM  = v.e_dstm;
    bus.e_Cnd   = v.e_cnd;
    bus.M_icode = v.m_icode;
    bus.m_Stat  = v.m_stat;
    bus.W_Stat  = v.w_stat;
    bus.W_icode = v.w_icode;
  endtask

  task automatic push(input string nm, input logic [7:0] ec, input logic [3:0] es);
    exp_t e;
    e.name = nm;
    e.ctrl = ec;
    e.stat = es;
    e.cyc  = m_cyc;
    e.ret  = m_ret;
    e.stl  = m_stl;
    e.msp  = m_msp;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_cyc = '0;
    m_ret = '0;
    m_stl = '0;
    m_msp = '0;
  endtask

  // Drive one cycle, queue its expectation, then advance the counter model
  // for the edge that closes this cycle.
  task automatic step(input string nm, input vec_t v, input logic [7:0] ec,
                      input logic [3:0] es);
    @(posedge clk);
    #1;
    drive(v);
    push(nm, ec, es);
    if (ec[0]) begin
      m_cyc = inc_sat(m_cyc);
      if (ec[7]) m_stl = inc_sat(m_stl);
      if ((v.e_icode == I_JXX) && !v.e_cnd) m_msp = inc_sat(m_msp);
      if ((v.w_icode != I_NOP) && (v.w_stat == S_AOK)) m_ret = inc_sat(m_ret);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".ctrl"},
              {24'd0, bus.F_stall, bus.D_stall, bus.W_stall, bus.D_bubble,
               bus.E_bubble, bus.M_bubble, bus.set_cc, bus.running},
              {24'd0, e.ctrl});
        check({e.name, ".proc_stat"}, {28'd0, bus.proc_stat}, {28'd0, e.stat});
        check({e.name, ".cyc_cnt"},   32'(bus.cyc_cnt),   32'(e.cyc));
        check({e.name, ".ret_cnt"},   32'(bus.ret_cnt),   32'(e.ret));
        check({e.name, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e.stl));
        check({e.name, ".misp_cnt"},  32'(bus.misp_cnt),  32'(e.msp));
      end
    end
  end

  initial begin : driver
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b0;
    drive(nv());
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step($sformatf("idle%0d", i), nv(), C_IDLE, S_AOK);

    v = nv(); v.start = 1'b1;
    step("start", v, C_IDLE, S_AOK);
    step("run_nop", nv(), C_RUN, S_AOK);

    v = nv(); v.e_icode = I_MRMOV; v.e_dstm = 4'h3; v.srca = 4'h3;
    step("lu_srcA", v, C_LU, S_AOK);
    v = nv(); v.e_icode = I_POP; v.e_dstm = 4'h4; v.srcb = 4'h4;
    step("lu_pop_srcB", v, C_LU, S_AOK);
    v = nv(); v.e_icode = I_MRMOV;
    step("lu_rnone", v, C_RUN, S_AOK);

    v = nv(); v.e_icode = I_JXX; v.e_cnd = 1'b0;
    step("misp", v, C_MP, S_AOK);
    v.e_cnd = 1'b1;
    step("jxx_taken", v, C_RUN, S_AOK);

    v = nv(); v.d_icode = I_RET;
    for (int i = 0; i < 3; i++) step($sformatf("ret_d%0d", i), v, C_RT, S_AOK);
    v.e_icode = I_MRMOV; v.e_dstm = 4'h3; v.srca = 4'h3;
    step("ret_plus_lu", v, C_LU, S_AOK);
    v = nv(); v.m_icode = I_RET;
    step("ret_m", v, C_RT, S_AOK);

    v = nv(); v.e_icode = I_OPQ;
    step("opq_cc", v, C_OPQ, S_AOK);
    v = nv(); v.w_icode = I_OPQ;
    step("retire", v, C_RUN, S_AOK);
    v = nv(); v.e_icode = I_OPQ; v.m_stat = S_ADR;
    step("m_exc", v, C_MEXC, S_AOK);
    v = nv(); v.w_stat = S_ADR; v.w_icode = I_MRMOV;
    step("w_exc", v, C_WEXC, S_AOK);

    v = nv(); v.start = 1'b1;
    step("halted_start", v, C_IDLE, S_ADR);
    step("halted", nv(), C_IDLE, S_ADR);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(nv());
    model_reset();
    push("reset_hold", C_IDLE, S_AOK);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("reset_rel", C_IDLE, S_AOK);

    v = nv(); v.start = 1'b1;
    step("start2", v, C_IDLE, S_AOK);
    v = nv(); v.w_icode = I_OPQ;
    for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), v, C_RUN, S_AOK);

    // Reset dropped between edges; the negedge sample precedes the next rising edge.
    @(posedge clk);
    #1;
    v = nv(); v.e_icode = I_MRMOV; v.e_dstm = 4'h3; v.srca = 4'h3;
    drive(v);
    #1;
    rst_n = 1'b0;
    model_reset();
    push("async_rst", C_IDLE, S_AOK);

    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 core: F, D, E, M, W.
- Generates the stall and bubble strobes for every pipeline register, plus the condition-code write enable.
- Owns the run/halt state machine: the core starts on a `start` pulse and freezes when an exception reaches writeback.
- Optionally keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; moves IDLE to RUN.
- D_icode  in  4  icode held in the D register.
- d_srcA, d_srcB  in  4 each  decode-stage source register IDs; 4'hF means none.
- E_icode  in  4  icode held in the E register.
- E_dstM  in  4  memory destination register in E.
- e_Cnd  in  1  branch condition computed in execute.
- M_icode  in  4  icode held in the M register.
- m_Stat  in  4  memory-stage status, one-hot {AOK,ADR,INS,HLT}.
- W_Stat  in  4  writeback status, same encoding.
- W_icode  in  4  icode held in the W register.
- F_stall, D_stall, W_stall  out  1 each  hold the named register.
- D_bubble, E_bubble, M_bubble  out  1 each  load a NOP with AOK status into the named register.
- set_cc  out  1  condition-code write enable.
- proc_stat  out  4  latched program status.
- running  out  1  high in RUN.
- cyc_cnt, ret_cnt, stall_cnt, misp_cnt  out  CNT_W each  performance counters.

Behaviour:
- Encodings:
  - icodes: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
  - Status: AOK=4'b1000, ADR=0100, INS=0010, HLT=0001.
- FSM states IDLE, RUN, HALTED. All state updates occur on the rising edge of clk.
  - Reset (any time, including mid-instruction) forces IDLE immediately.
  - Reset also sets proc_stat=AOK and clears every counter.
  - IDLE -> RUN on start=1.
  - RUN -> HALTED on the first edge where W_Stat != AOK; proc_stat latches W_Stat on that edge.
  - HALTED is left only by reset. start is ignored outside IDLE.
- Condition terms (combinational):
  - LU (load/use): E_icode in {MRMOV,POP}, E_dstM != F, and E_dstM equals d_srcA or d_srcB.
  - RT: RET is present in D_icode, E_icode or M_icode.
  - MP (mispredict): E_icode==JXX and e_Cnd==0.
  - EXC: m_Stat != AOK or W_Stat != AOK.
- Outputs in RUN (combinational, same cycle as the inputs):
  - F_stall = LU | RT.
  - D_stall = LU.
  - D_bubble = MP | (RT & ~LU).
  - E_bubble = MP | LU.
  - M_bubble = EXC.
  - W_stall = (W_Stat != AOK).
  - set_cc = (E_icode==OPQ) & ~EXC.
  - running = 1.
- Outputs in IDLE and HALTED:
  - F_stall = D_stall = W_stall = 1.
  - E_bubble = M_bubble = 1.
  - D_bubble = 0, set_cc = 0, running = 0.
- A stall and a bubble are never both high for the same register; the RUN equations guarantee it for D.
- Counters advance only in RUN and saturate at all-ones (no wrap):
  - cyc_cnt increments every cycle.
  - ret_cnt increments when W_icode != NOP and W_Stat == AOK. Bubbles and real NOPs are not counted.
  - stall_cnt increments when F_stall is high.
  - misp_cnt increments when MP is high.
- On the RUN->HALTED edge, counters still count for that final RUN cycle.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined: all four counters are instantiated and behave as specified above.
- Undefined: no counter flops are built, and cyc_cnt, ret_cnt, stall_cnt and misp_cnt are tied to 0. All control outputs are unchanged.

Decomposition:
- Shared package y86_pkg holds:
  - the icode constants;
  - the status one-hot constants;
  - RNONE=4'hF;
  - the controller state enum {IDLE,RUN,HALTED}.
- One sub-module, sat_counter: parameter W; ports clk, rst_n, inc; output q; increments saturating at all-ones. It is instantiated four times under PERF_CNT_EN.

Test Plan:
- Reset, then no start for 5 cycles -> running=0, F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, proc_stat=4'b1000, all counters 0.
- start pulse, then E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt increments by 1.
- E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; misp_cnt=1. Repeating with e_Cnd=1 -> no bubbles.
- D_icode=9 for 3 consecutive cycles -> F_stall=1, D_bubble=1 each cycle. Adding load/use in the same cycle -> D_stall=1, D_bubble=0.
- m_Stat=0100 with E_icode=6 -> M_bubble=1, set_cc=0. Next cycle W_Stat=0100 -> W_stall=1, then state HALTED, proc_stat=0100, running=0.
- With CNT_W=4: run 20 cycles -> cyc_cnt=15 (saturated). Assert rst_n low mid-run -> all outputs return to reset values asynchronously, before the next clock edge.
